// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - MemOP encoding, FSM states and lane helper functions
package dmem_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    function automatic logic memop_legal(input logic [2:0] memop, input logic wr);
        case (memop)
            MOP_B, MOP_H, MOP_W: memop_legal = 1'b1;
            MOP_BU, MOP_HU:      memop_legal = ~wr;
            default:             memop_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] memop, input logic [1:0] lo);
        case (memop)
            MOP_B, MOP_BU: byte_en = 4'b0001 << lo;
            MOP_H, MOP_HU: byte_en = lo[1] ? 4'b1100 : 4'b0011;
            MOP_W:         byte_en = 4'b1111;
            default:       byte_en = 4'b0000;
        endcase
    endfunction

    // Operand is the read word already shifted so the addressed lane sits at bit 0.
    function automatic logic [31:0] load_extend(input logic [2:0] memop, input logic [31:0] s);
        case (memop)
            MOP_B:   load_extend = {{24{s[7]}}, s[7:0]};
            MOP_BU:  load_extend = {24'b0, s[7:0]};
            MOP_H:   load_extend = {{16{s[15]}}, s[15:0]};
            MOP_HU:  load_extend = {16'b0, s[15:0]};
            MOP_W:   load_extend = s;
            default: load_extend = 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - byte enables, store lane steering, load extension, access legality
module dmem_lane_unit (
    input  logic [2:0]  memop,
    input  logic        wr,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        bad
);
    import dmem_pkg::*;

    logic is_half;
    logic is_word;

    always_comb begin
        is_half = (memop == MOP_H) || (memop == MOP_HU);
        is_word = (memop == MOP_W);
        be      = byte_en(memop, addr_lo);
        // Replicate the store data into every lane; the byte enables pick the live ones.
        case (memop)
            MOP_B:   wdata_lane = {4{wdata[7:0]}};
            MOP_H:   wdata_lane = {2{wdata[15:0]}};
            default: wdata_lane = wdata;
        endcase
        rdata_ext = load_extend(memop, rword >> {addr_lo, 3'b000});
        bad       = ~memop_legal(memop, wr)
                  | (is_half & addr_lo[0])
                  | (is_word & (addr_lo != 2'b00));
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data memory with valid/ready request and response channels
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wr,
    input  logic [2:0]  req_memop,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    import dmem_pkg::*;

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [2:0]    memop_q, memop_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          idle;
    logic [2:0]    lu_memop;
    logic          lu_wr;
    logic [1:0]    lu_lo;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   wdata_lane;
    logic [31:0]   rdata_ext;
    logic          lane_bad;
    logic          oob;
    logic          mem_we;

    assign idle      = (state_q == ST_IDLE);
    assign req_ready = rst & idle;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // The lane unit checks the live request in IDLE and the captured one afterwards.
    assign lu_memop = idle ? req_memop     : memop_q;
    assign lu_wr    = idle ? req_wr        : wr_q;
    assign lu_lo    = idle ? req_addr[1:0] : addr_q[1:0];
    assign rword    = mem[addr_q[2 +: AW]];
    assign oob      = ({1'b0, req_addr} >= ADDR_LIMIT);
    assign mem_we   = (state_q == ST_ACCESS) & wr_q;

    dmem_lane_unit u_lane (
        .memop      (lu_memop),
        .wr         (lu_wr),
        .addr_lo    (lu_lo),
        .rword      (rword),
        .wdata      (wdata_q),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .bad        (lane_bad)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        memop_d     = memop_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_addr[AW+1:0];
                    wr_d    = req_wr;
                    memop_d = req_memop;
                    wdata_d = req_wdata;
                    if (lane_bad || oob) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'b0;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = wr_q ? 32'b0 : rdata_ext;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            memop_q     <= 3'b0;
            wdata_q     <= 32'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            memop_q     <= memop_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array is not reset; an async reset forces state_q to IDLE, which also blocks a pending write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr_q[2 +: AW]][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;

    localparam int WAITC = 2;
    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'b0;
    logic        req_wr = 1'b0;
    logic [2:0]  req_memop = W;
    logic [31:0] req_wdata = 32'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAITC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wr    (req_wr),
        .req_memop (req_memop),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic        seen = 1'b0;
    logic [31:0] held_rdata;
    logic        held_err;
    exp_t        e;

    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            if (!seen) begin
                seen       = 1'b1;
                held_rdata = rsp_rdata;
                held_err   = rsp_err;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_rsp: got rdata %h err %b expected no response", rsp_rdata, rsp_err);
                end else begin
                    e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_latency", 32'(cyc + 1 - e.acc_cyc), e.err ? 32'd1 : 32'(WAITC + 2));
                end
            end else begin
                check("rsp_rdata_stable", rsp_rdata, held_rdata);
                check("rsp_err_stable", 32'(rsp_err), 32'(held_err));
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] m,
                         input logic [31:0] d, input logic [31:0] er, input logic ee,
                         input bit expect_rsp);
        int t = 0;
        @(negedge clk);
        req_addr  = a;
        req_wr    = w;
        req_memop = m;
        req_wdata = d;
        req_valid = 1'b1;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept for addr %h expected accept", a);
            req_valid = 1'b0;
            return;
        end
        last_acc = cyc + 1;
        if (expect_rsp) sb.push_back('{er, ee, cyc + 1});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_memop = 3'($urandom);
        req_wr    = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || rsp_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    int hs;

    initial begin
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_req_ready", 32'(req_ready), 32'd0);
            check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
            check("reset_rsp_rdata", rsp_rdata, 32'd0);
        end
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", 32'(req_ready), 32'd1);

        issue(32'h10, 1, W,  32'hDEADBEEF, 32'h0,        0, 1);
        issue(32'h10, 0, W,  32'h0,        32'hDEADBEEF, 0, 1);
        issue(32'h13, 1, B,  32'h00000080, 32'h0,        0, 1);
        issue(32'h13, 0, B,  32'h0,        32'hFFFFFF80, 0, 1);
        issue(32'h13, 0, BU, 32'h0,        32'h00000080, 0, 1);
        issue(32'h10, 0, W,  32'h0,        32'h80ADBEEF, 0, 1);
        issue(32'h12, 1, H,  32'hAAAA1234, 32'h0,        0, 1);
        issue(32'h12, 0, H,  32'h0,        32'h00001234, 0, 1);
        issue(32'h10, 0, B,  32'h0,        32'hFFFFFFEF, 0, 1);
        issue(32'h10, 0, HU, 32'h0,        32'h0000BEEF, 0, 1);
        issue(32'h11, 0, H,  32'h0,        32'h0,        1, 1);
        issue(32'h1000, 1, W, 32'h55555555, 32'h0,       1, 1);
        issue(32'h10, 0, 3'b011, 32'h0,    32'h0,        1, 1);
        issue(32'h10, 1, BU, 32'h000000FF, 32'h0,        1, 1);
        issue(32'h12, 1, W,  32'h77777777, 32'h0,        1, 1);
        issue(32'h10, 0, W,  32'h0,        32'h1234BEEF, 0, 1);
        drain();

        rsp_ready = 1'b0;
        issue(32'h10, 0, W, 32'h0, 32'h1234BEEF, 0, 1);
        fork
            issue(32'h10, 0, H, 32'h0, 32'hFFFFBEEF, 0, 1);
            begin
                repeat (8) begin
                    @(negedge clk);
                    check("bp_req_ready", 32'(req_ready), 32'd0);
                end
                #1;
                rsp_ready = 1'b1;
                hs = cyc + 1;
            end
        join
        check("bp_pending_accept_cycle", 32'(last_acc), 32'(hs + 1));
        drain();

        issue(32'h20, 1, W, 32'hCAFEF00D, 32'h0, 0, 1);
        drain();
        issue(32'h20, 1, W, 32'h11111111, 32'h0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_req_ready", 32'(req_ready), 32'd0);
        check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        issue(32'h20, 0, W, 32'h0, 32'hCAFEF00D, 0, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
